// File: rtl/shiftreg_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shiftreg_arb_ctrl
// Purpose  : Round-robin arbiter and serializer that owns a single serial
//            shift path shared by two requesters. The winner's parallel word
//            is captured and shifted out LSB-first, one bit per clock, with a
//            valid qualifier, followed by a programmable idle gap.
// Params   : WIDTH - data bits per word (>= 2)
//            GAP   - idle cycles after each word (>= 0)
// Ports    : clk, rst          - clock (rising edge), async active-high reset
//            req0/data0        - requester 0 request and word
//            req1/data1        - requester 1 request and word
//            ack0/ack1         - one-cycle capture pulse per requester
//            ser_out/ser_valid - serial bit and its qualifier
//            busy              - controller is not idle
//            done              - one-cycle pulse after the last serial bit
//            owner             - requester of the current/last word
// Macro    : SHIFTREG_ARB_PARITY_EN - when defined, an even-parity bit is
//            appended after the data bits of every word.
// Revision : 1.0 - initial release
// ============================================================================
module shiftreg_arb_ctrl #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack0,
  output logic             ack1,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done,
  output logic             owner
);

`ifdef SHIFTREG_ARB_PARITY_EN
  localparam int c_NBITS = WIDTH + 1;
`else
  localparam int c_NBITS = WIDTH;
`endif
  localparam int c_CW = $clog2(c_NBITS);
  localparam int c_GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(c_NBITS - 1);
  localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state_q;
  logic [c_NBITS-1:0] shreg_q;
  logic [c_CW-1:0]    cnt_q;
  logic [c_GW-1:0]    gap_cnt_q;
  logic               last_q;
  logic               ack0_q;
  logic               ack1_q;
  logic               ser_out_q;
  logic               ser_valid_q;
  logic               busy_q;
  logic               done_q;
  logic               owner_q;

  logic               w_pick1;
  logic [WIDTH-1:0]   w_data;
  logic [c_NBITS-1:0] w_load;
  logic               w_last_bit;
  logic               w_gap_end;
  logic               w_free;
  logic               w_grant;

  always_comb begin
    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    w_pick1    = req1 & (~req0 | ~last_q);
    w_data     = w_pick1 ? data1 : data0;
`ifdef SHIFTREG_ARB_PARITY_EN
    w_load     = {^w_data, w_data};
`else
    w_load     = w_data;
`endif
    w_last_bit = (state_q == ST_SHIFT) && (cnt_q == c_CNT_LAST);
    w_gap_end  = (state_q == ST_GAP) && (gap_cnt_q == c_GAP_LAST);
    // The edge that ends a word (GAP=0) or ends the gap acts as an IDLE edge,
    // so the next grant can land there and keep the serial stream contiguous.
    w_free     = (state_q == ST_IDLE) || w_gap_end || (w_last_bit && (GAP == 0));
    w_grant    = w_free && (req0 || req1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      gap_cnt_q   <= '0;
      last_q      <= 1'b1;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      owner_q     <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      done_q <= w_last_bit;
      if (w_grant) begin
        state_q     <= ST_SHIFT;
        shreg_q     <= w_load;
        cnt_q       <= '0;
        ser_out_q   <= w_load[0];
        ser_valid_q <= 1'b1;
        busy_q      <= 1'b1;
        ack0_q      <= ~w_pick1;
        ack1_q      <= w_pick1;
        owner_q     <= w_pick1;
        last_q      <= w_pick1;
      end else begin
        case (state_q)
          ST_SHIFT: begin
            if (w_last_bit) begin
              ser_out_q   <= 1'b0;
              ser_valid_q <= 1'b0;
              if (GAP == 0) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q   <= ST_GAP;
                gap_cnt_q <= '0;
              end
            end else begin
              // ser_out mirrors shreg[0] after the shift, registered directly.
              shreg_q   <= shreg_q >> 1;
              ser_out_q <= shreg_q[1];
              cnt_q     <= cnt_q + c_CW'(1);
            end
          end
          ST_GAP: begin
            if (w_gap_end) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              gap_cnt_q <= gap_cnt_q + c_GW'(1);
            end
          end
          default: begin
            state_q     <= ST_IDLE;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign owner     = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_shiftreg_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shiftreg_arb_ctrl
// Purpose  : Self-checking bench for shiftreg_arb_ctrl. Two instances are
//            driven: GAP=1 (instance 0) and GAP=0 (instance 1), both WIDTH=4.
//            A timeline model predicts every output each cycle; directed
//            scenarios pin serial streams and timing with literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shiftreg_arb_ctrl;
  localparam int W  = 4;
  localparam int G0 = 1;
  localparam int G1 = 0;
`ifdef SHIFTREG_ARB_PARITY_EN
  localparam int NB = W + 1;
  localparam logic [31:0] L_1101 = 32'b11101;
  localparam logic [31:0] L_0011 = 32'b00011;
  localparam logic [31:0] L_1010 = 32'b01010;
  localparam logic [31:0] L_1001 = 32'b01001;
  localparam logic [31:0] L_B2B  = 32'b1000101111;
`else
  localparam int NB = W;
  localparam logic [31:0] L_1101 = 32'b1101;
  localparam logic [31:0] L_0011 = 32'b0011;
  localparam logic [31:0] L_1010 = 32'b1010;
  localparam logic [31:0] L_1001 = 32'b1001;
  localparam logic [31:0] L_B2B  = 32'b00011111;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic         req0 [2];
  logic         req1 [2];
  logic [W-1:0] data0 [2];
  logic [W-1:0] data1 [2];
  logic ack0 [2];
  logic ack1 [2];
  logic ser_out [2];
  logic ser_valid [2];
  logic busy [2];
  logic done [2];
  logic owner [2];

  shiftreg_arb_ctrl #(.WIDTH(W), .GAP(G0)) u_dut_g1 (
    .clk(clk), .rst(rst),
    .req0(req0[0]), .data0(data0[0]), .req1(req1[0]), .data1(data1[0]),
    .ack0(ack0[0]), .ack1(ack1[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
    .busy(busy[0]), .done(done[0]), .owner(owner[0])
  );

  shiftreg_arb_ctrl #(.WIDTH(W), .GAP(G1)) u_dut_g0 (
    .clk(clk), .rst(rst),
    .req0(req0[1]), .data0(data0[1]), .req1(req1[1]), .data1(data1[1]),
    .ack0(ack0[1]), .ack1(ack1[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
    .busy(busy[1]), .done(done[1]), .owner(owner[1])
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int j, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h (t=%0t)", name, j, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Timeline model: a word granted at edge k owns edges k..k+NB-1 for bits,
  // done at edge k+NB, and the path is free again from edge k+NB+gap.
  // ---------------------------------------------------------------------------
  int cyc = 0;
  int m_free [2];
  int m_k [2];
  int m_done_at [2];
  logic [NB-1:0] m_bits [2];
  bit m_last [2];
  bit m_owner [2];
  bit e_ack0 [2];
  bit e_ack1 [2];
  bit e_so [2];
  bit e_sv [2];
  bit e_busy [2];
  bit e_done [2];

  function automatic logic [NB-1:0] frame(input logic [W-1:0] d);
`ifdef SHIFTREG_ARB_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  task automatic mdl_reset(input int j);
    m_free[j] = 0; m_k[j] = -1000; m_done_at[j] = -1; m_bits[j] = '0;
    m_last[j] = 1'b1; m_owner[j] = 1'b0;
    e_ack0[j] = 0; e_ack1[j] = 0; e_so[j] = 0; e_sv[j] = 0; e_busy[j] = 0; e_done[j] = 0;
  endtask

  task automatic mdl_step(input int j, input int gap);
    bit grant;
    bit win1;
    int off;
    e_done[j] = (cyc == m_done_at[j]);
    grant = (cyc >= m_free[j]) && (req0[j] || req1[j]);
    win1  = req1[j] && (!req0[j] || !m_last[j]);
    if (grant) begin
      m_k[j]       = cyc;
      m_bits[j]    = frame(win1 ? data1[j] : data0[j]);
      m_free[j]    = cyc + NB + gap;
      m_done_at[j] = cyc + NB;
      m_last[j]    = win1;
      m_owner[j]   = win1;
    end
    e_ack0[j] = grant && !win1;
    e_ack1[j] = grant && win1;
    off       = cyc - m_k[j];
    e_sv[j]   = (off >= 0) && (off < NB);
    e_so[j]   = e_sv[j] ? m_bits[j][off] : 1'b0;
    e_busy[j] = (cyc < m_free[j]);
  endtask

  initial begin
    for (int j = 0; j < 2; j++) mdl_reset(j);
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int j = 0; j < 2; j++) mdl_reset(j);
      end else begin
        for (int j = 0; j < 2; j++) mdl_step(j, (j == 0) ? G0 : G1);
        cyc++;
      end
    end
  end

  // Compare every output of both instances against the model after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int j = 0; j < 2; j++) begin
        check("ack0", j, ack0[j], e_ack0[j]);
        check("ack1", j, ack1[j], e_ack1[j]);
        check("ser_valid", j, ser_valid[j], e_sv[j]);
        check("ser_out", j, ser_out[j], e_so[j]);
        check("busy", j, busy[j], e_busy[j]);
        check("done", j, done[j], e_done[j]);
        check("owner", j, owner[j], m_owner[j]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Requester drivers: queue index 2*j+r holds pending words for requester r
  // of instance j. On ack the next word is presented, or req is dropped.
  // ---------------------------------------------------------------------------
  logic [W-1:0] wq [4][$];

  initial begin
    for (int j = 0; j < 2; j++) begin
      req0[j] = 0; req1[j] = 0; data0[j] = '0; data1[j] = '0;
    end
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int j = 0; j < 2; j++) begin
          if (req0[j] && ack0[j]) begin
            if (wq[2*j].size() > 0) data0[j] = wq[2*j].pop_front();
            else req0[j] = 1'b0;
          end else if (!req0[j] && wq[2*j].size() > 0) begin
            req0[j] = 1'b1; data0[j] = wq[2*j].pop_front();
          end
          if (req1[j] && ack1[j]) begin
            if (wq[2*j+1].size() > 0) data1[j] = wq[2*j+1].pop_front();
            else req1[j] = 1'b0;
          end else if (!req1[j] && wq[2*j+1].size() > 0) begin
            req1[j] = 1'b1; data1[j] = wq[2*j+1].pop_front();
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Observation window: serial bits (DUT and model), ack/done cycle offsets.
  // ---------------------------------------------------------------------------
  logic [31:0] c_dut;
  logic [31:0] c_mdl;
  int c_nv;
  int c_vfirst;
  int c_vlast;
  int c_ack [$];
  int c_own [$];
  int c_done [$];

  task automatic collect(input int j, input int n);
    int mv;
    mv = 0; c_dut = '0; c_mdl = '0; c_nv = 0; c_vfirst = -1; c_vlast = -1;
    c_ack.delete(); c_own.delete(); c_done.delete();
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (ser_valid[j]) begin
        if (c_nv < 32) c_dut[c_nv] = ser_out[j];
        c_nv++;
        if (c_vfirst < 0) c_vfirst = i;
        c_vlast = i;
      end
      if (e_sv[j]) begin
        if (mv < 32) c_mdl[mv] = e_so[j];
        mv++;
      end
      if (ack0[j] || ack1[j]) begin
        c_ack.push_back(i);
        c_own.push_back(int'(owner[j]));
      end
      if (done[j]) c_done.push_back(i);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic logic [31:0] fld(input logic [31:0] v, input int lo, input int n);
    return (v >> lo) & ((32'd1 << n) - 32'd1);
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  bit ok;

  initial begin
    // Reset, then ten quiet cycles with every output low.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        check("idle_busy", j, busy[j], 0);
        check("idle_valid", j, ser_valid[j], 0);
        check("idle_outs", j, {ack0[j], ack1[j], ser_out[j], done[j], owner[j]}, 0);
      end
    end

    // Single word 1101 from requester 0, a second word queued right behind it.
    wq[0].push_back(4'b1101);
    wq[0].push_back(4'b0110);
    collect(0, 20);
    check("single_stream", 0, fld(c_dut, 0, NB), L_1101);
    check("single_model_stream", 0, fld(c_mdl, 0, NB), L_1101);
    check("single_owner", 0, qat(c_own, 0), 0);
    check("single_ack_count", 0, c_ack.size(), 2);
    check("single_done_lat", 0, qat(c_done, 0) - qat(c_ack, 0), NB);
    check("single_next_grant", 0, qat(c_ack, 1) - qat(c_ack, 0), NB + G0);

    // Tie: both held, requester 0 first after reset, then alternation.
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      wq[0].push_back(4'b0011);
      wq[1].push_back(4'b1010);
    end
    collect(0, 45);
    check("tie_ack_count", 0, c_ack.size(), 6);
    check("tie_owner0", 0, qat(c_own, 0), 0);
    check("tie_owner1", 0, qat(c_own, 1), 1);
    check("tie_owner2", 0, qat(c_own, 2), 0);
    check("tie_owner3", 0, qat(c_own, 3), 1);
    check("tie_word0", 0, fld(c_dut, 0, NB), L_0011);
    check("tie_word1", 0, fld(c_dut, NB, NB), L_1010);
    check("tie_model_word1", 0, fld(c_mdl, NB, NB), L_1010);

    // Reset during the second serial bit; the pending req1 word follows.
    pulse_reset();
    wq[1].push_back(4'b0110);
    wq[1].push_back(4'b1001);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = ack1[0];
    end
    check("midrst_wait_ack", 0, ok, 1);
    @(negedge clk);
    check("midrst_valid_before", 0, ser_valid[0], 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", 0, ser_valid[0], 0);
    check("midrst_busy", 0, busy[0], 0);
    check("midrst_done", 0, done[0], 0);
    @(negedge clk);
    rst = 1'b0;
    collect(0, 14);
    check("midrst_ack_count", 0, c_ack.size(), 1);
    check("midrst_owner", 0, qat(c_own, 0), 1);
    check("midrst_done_count", 0, c_done.size(), 1);
    check("midrst_done_lat", 0, qat(c_done, 0) - qat(c_ack, 0), NB);
    check("midrst_stream", 0, fld(c_dut, 0, NB), L_1001);

    // GAP=0 instance: two words back to back with no idle cycle between.
    wq[3].push_back(4'b1111);
    wq[3].push_back(4'b0001);
    collect(1, 25);
    check("b2b_valid_count", 1, c_nv, 2 * NB);
    check("b2b_contiguous", 1, c_vlast - c_vfirst + 1, 2 * NB);
    check("b2b_done0", 1, qat(c_done, 0) - qat(c_ack, 0), NB);
    check("b2b_done1", 1, qat(c_done, 1) - qat(c_ack, 0), 2 * NB);
    check("b2b_stream", 1, fld(c_dut, 0, 2 * NB), L_B2B);
    check("b2b_model_stream", 1, fld(c_mdl, 0, 2 * NB), L_B2B);

    // Randomized traffic on all four requesters with occasional async resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      for (int q = 0; q < 4; q++) begin
        if (wq[q].size() < 2 && $urandom_range(2, 0) == 0) wq[q].push_back(W'($urandom));
      end
      if (i % 700 == 350) begin
        #3 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    for (int q = 0; q < 4; q++) wq[q].delete();
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
